mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register and writeback formatter of the MIPS datapath; sits directly upstream of REG.
//  Captures MEM-stage results, aligns and extends load data, and drives REG write port (REG_address_wb/regwrite/data_wb).
//  One-cycle latency; supports stall (hold) and flush (bubble).
// PARAMETERS
//  DATA_W   32  datapath width (only 32 supported)
//  ADDR_W   5   register-address width
// PORTS
//  clk               in   1       rising-edge clock
//  reset             in   1       asynchronous, active-low reset
//  mem_valid         in   1       MEM slot holds a real instruction
//  mem_regwrite      in   1       instruction writes a register
//  mem_memtoreg      in   1       1: result = load data, 0: ALU result
//  mem_load_size     in   2       00 byte, 01 half, 10 word, 11 = word
//  mem_load_unsigned in   1       1: zero-extend (lbu/lhu), 0: sign-extend
//  mem_addr_lo       in   2       byte offset of load address
//  mem_alu_result    in   32      ALU result
//  mem_load_data     in   32      raw word from data memory
//  mem_wr_addr       in   5       destination register
//  stall             in   1       hold WB contents
//  flush             in   1       insert bubble
//  REG_address_wb    out  5       to REG write address
//  regwrite          out  1       to REG write enable
//  data_wb           out  32      to REG write data
//  wb_valid          out  1       WB slot holds a real instruction
// BEHAVIOUR
//  - reset low (async): wb_valid=0, regwrite=0, REG_address_wb=0, data_wb=0; all internal regs 0.
//  - Per posedge, priority: flush > stall > load. flush: wb_valid<=0, regwrite<=0 (other regs don't-care, kept).
//    stall (no flush): all regs hold. Otherwise capture MEM inputs; wb_valid<=mem_valid.
//  - regwrite = wb_valid & wb_regwrite & (REG_address_wb != 0); writes to $0 always suppressed.
//  - data_wb formed combinationally from registered fields (same cycle as wb_valid):
//    memtoreg=0 -> alu_result. memtoreg=1 -> big-endian select from load_data:
//    byte: addr_lo 0..3 -> bits [31:24],[23:16],[15:8],[7:0]; half: addr_lo[1] 0->[31:16], 1->[15:0], addr_lo[0] ignored;
//    word: full word, addr_lo ignored. Extension per load_unsigned; size 11 treated as word.
//  - Latency: MEM inputs at posedge N appear on outputs after N, written into REG at posedge N+1.
//  - Outputs must be stable whole cycle; no combinational path from mem_* to outputs.
//  - reset asserted mid-stall/flush: reset wins; on release next capture is a normal load.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: adds output retire_cnt [31:0]; increments by 1 on every posedge where
//    wb_valid=1 and stall=0 (instruction leaves WB); wraps FFFFFFFF->0; reset to 0; flush doesn't decrement.
//  Not defined: port and counter absent; no other behaviour change.
// STRUCTURE
//  mips_pkg: LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10 constants, DATA_W/ADDR_W defaults.
//  Sub-module load_align (combinational: load_data, addr_lo, size, unsigned -> 32-bit extended value).
//  Top: one register bank + regwrite gating + optional counter.
// TESTING
//  1 ALU write: mem_valid=1,regwrite=1,memtoreg=0,alu=DEADBEEF,wr_addr=3 -> next cycle regwrite=1,addr=3,data_wb=DEADBEEF.
//  2 Loads from 8081F0F7: lb off0 -> FFFFFF80; lbu off3 -> 000000F7; lh off2 -> FFFFF0F7; lhu off0 -> 00008081; lw -> 8081F0F7.
//  3 $0 suppression: regwrite=1,wr_addr=0,alu=12345678 -> regwrite=0, wb_valid=1.
//  4 Stall/flush: load CAFEBABE->r2, then stall 3 cycles with new inputs -> outputs hold r2/CAFEBABE; stall+flush together -> wb_valid=0,regwrite=0.
//  5 Async reset mid-run: drop reset between edges -> all outputs 0 immediately; release, drive r5/ABCDEF01 -> appears next cycle.
//  6 With WB_RETIRE_CNT_EN: 10 valid instrs, 2 stall cycles, 1 flush -> retire_cnt counts only unstalled valid exits (=9 when flush kills one).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: load-size encodings and default widths.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Load-size encodings carried down the pipeline with each load.
    // The fourth code (2'b11) is not named; it behaves as a word load.
    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    // Sign- or zero-extend a byte to the full datapath width.
    function automatic logic [DATA_W-1:0] extend_byte(input logic [7:0] b, input logic zero_ext);
        return zero_ext ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
    endfunction

    // Sign- or zero-extend a halfword to the full datapath width.
    function automatic logic [DATA_W-1:0] extend_half(input logic [15:0] h, input logic zero_ext);
        return zero_ext ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: purely combinational big-endian load extractor.
// Picks the addressed byte/halfword out of the raw memory word and extends it.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] load_data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Big-endian lane selection: offset 0 is the most significant byte/half.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0:    byte_sel = load_data[31:24];
            2'd1:    byte_sel = load_data[23:16];
            2'd2:    byte_sel = load_data[15:8];
            default: byte_sel = load_data[7:0];
        endcase
        // Halfword selection uses only addr_lo[1]; the low offset bit is ignored.
        half_sel = addr_lo[1] ? load_data[15:0] : load_data[31:16];
    end

    // Size decode and extension; the unnamed code 2'b11 falls through to word.
    always_comb begin
        value = load_data;
        case (size)
            LS_BYTE: value = extend_byte(byte_sel, load_unsigned);
            LS_HALF: value = extend_half(half_sel, load_unsigned);
            default: value = load_data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus writeback formatting for REG.
// All outputs are derived only from registered state, so nothing combinational
// passes from the MEM inputs to REG. Flush beats stall beats normal capture.
// Optional feature macro: WB_RETIRE_CNT_EN adds the retire_cnt output.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,   // only 32 is supported
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic              mem_memtoreg,
    input  logic [1:0]        mem_load_size,
    input  logic              mem_load_unsigned,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [ADDR_W-1:0] mem_wr_addr,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] REG_address_wb,
    output logic              regwrite,
    output logic [DATA_W-1:0] data_wb,
    output logic              wb_valid
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_cnt
`endif
);

    logic              valid_q,      valid_d;
    logic              regwrite_q,   regwrite_d;
    logic              memtoreg_q,   memtoreg_d;
    logic [1:0]        size_q,       size_d;
    logic              unsigned_q,   unsigned_d;
    logic [1:0]        addr_lo_q,    addr_lo_d;
    logic [DATA_W-1:0] alu_q,        alu_d;
    logic [DATA_W-1:0] load_q,       load_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;

    logic [DATA_W-1:0] load_value;

    // Next-state selection: flush kills the slot, stall holds it, else capture MEM.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_lo_d  = addr_lo_q;
        alu_d      = alu_q;
        load_d     = load_q;
        wr_addr_d  = wr_addr_q;
        if (flush) begin
            // Only the qualifiers are cleared; data fields keep their old contents.
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (!stall) begin
            valid_d    = mem_valid;
            regwrite_d = mem_regwrite;
            memtoreg_d = mem_memtoreg;
            size_d     = mem_load_size;
            unsigned_d = mem_load_unsigned;
            addr_lo_d  = mem_addr_lo;
            alu_d      = mem_alu_result;
            load_d     = mem_load_data;
            wr_addr_d  = mem_wr_addr;
        end
    end

    // Pipeline register bank with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_lo_q  <= 2'b00;
            alu_q      <= '0;
            load_q     <= '0;
            wr_addr_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_lo_q  <= addr_lo_d;
            alu_q      <= alu_d;
            load_q     <= load_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    load_align u_load_align (
        .load_data     (load_q),
        .addr_lo       (addr_lo_q),
        .size          (size_q),
        .load_unsigned (unsigned_q),
        .value         (load_value)
    );

    // Writeback drive: $0 writes are never issued to REG.
    always_comb begin
        wb_valid       = valid_q;
        REG_address_wb = wr_addr_q;
        regwrite       = valid_q & regwrite_q & (wr_addr_q != '0);
        data_wb        = memtoreg_q ? load_value : alu_q;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // An instruction retires when it leaves a valid WB slot without being held.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_q && !stall) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // Retire counter register; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage; define WB_RETIRE_CNT_EN to also cover retire_cnt.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_regwrite;
    logic        mem_memtoreg;
    logic [1:0]  mem_load_size;
    logic        mem_load_unsigned;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [4:0]  mem_wr_addr;
    logic        stall;
    logic        flush;
    logic [4:0]  REG_address_wb;
    logic        regwrite;
    logic [31:0] data_wb;
    logic        wb_valid;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk               (clk),
        .reset             (reset),
        .mem_valid         (mem_valid),
        .mem_regwrite      (mem_regwrite),
        .mem_memtoreg      (mem_memtoreg),
        .mem_load_size     (mem_load_size),
        .mem_load_unsigned (mem_load_unsigned),
        .mem_addr_lo       (mem_addr_lo),
        .mem_alu_result    (mem_alu_result),
        .mem_load_data     (mem_load_data),
        .mem_wr_addr       (mem_wr_addr),
        .stall             (stall),
        .flush             (flush),
        .REG_address_wb    (REG_address_wb),
        .regwrite          (regwrite),
        .data_wb           (data_wb),
        .wb_valid          (wb_valid)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt        (retire_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full writeback port in one go.
    task automatic chk_wb(input string tag, input logic v, input logic rw,
                          input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, v});
        chk({tag, ".regwr"}, {31'd0, regwrite}, {31'd0, rw});
        chk({tag, ".addr"},  {27'd0, REG_address_wb}, {27'd0, a});
        chk({tag, ".data"},  data_wb, d);
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [1:0] sz,
                         input logic un, input logic [1:0] lo, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [4:0] wa);
        mem_valid         = v;
        mem_regwrite      = rw;
        mem_memtoreg      = m2r;
        mem_load_size     = sz;
        mem_load_unsigned = un;
        mem_addr_lo       = lo;
        mem_alu_result    = alu;
        mem_load_data     = ld;
        mem_wr_addr       = wa;
    endtask

    // Issue a load of 8081F0F7 with the given size/extension/offset and check the result.
    task automatic load_case(input string tag, input logic [1:0] sz, input logic un,
                             input logic [1:0] lo, input logic [31:0] exp);
        drive(1'b1, 1'b1, 1'b1, sz, un, lo, 32'h1111_1111, 32'h8081_F0F7, 5'd9);
        tick();
        chk_wb(tag, 1'b1, 1'b1, 5'd9, exp);
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);

        // Reset state
        #12;
        chk_wb("reset", 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        reset = 1'b1;

        // 1: ALU writeback
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'hDEAD_BEEF, 32'h0, 5'd3);
        tick();
        chk_wb("alu", 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);

        // 2: load alignment and extension
        load_case("lb0",  2'b00, 1'b0, 2'd0, 32'hFFFF_FF80);
        load_case("lbu3", 2'b00, 1'b1, 2'd3, 32'h0000_00F7);
        load_case("lb1",  2'b00, 1'b0, 2'd1, 32'hFFFF_FF81);
        load_case("lbu2", 2'b00, 1'b1, 2'd2, 32'h0000_00F0);
        load_case("lh2",  2'b01, 1'b0, 2'd2, 32'hFFFF_F0F7);
        load_case("lhu0", 2'b01, 1'b1, 2'd0, 32'h0000_8081);
        load_case("lhu3", 2'b01, 1'b1, 2'd3, 32'h0000_F0F7);
        load_case("lw",   2'b10, 1'b0, 2'd2, 32'h8081_F0F7);
        load_case("lw11", 2'b11, 1'b1, 2'd1, 32'h8081_F0F7);

        // 3: writes to $0 are suppressed; invalid slot never writes
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'h1234_5678, 32'h0, 5'd0);
        tick();
        chk_wb("r0", 1'b1, 1'b0, 5'd0, 32'h1234_5678);
        drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'h0000_0042, 32'h0, 5'd4);
        tick();
        chk_wb("bubble", 1'b0, 1'b0, 5'd4, 32'h0000_0042);

        // 4: stall holds, stall+flush kills
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'hCAFE_BABE, 32'h0, 5'd2);
        tick();
        chk_wb("ld_r2", 1'b1, 1'b1, 5'd2, 32'hCAFE_BABE);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'(i), 32'h0BAD_0000 + 32'(i), 32'h5555_AAAA, 5'd7);
            tick();
            chk_wb("stall", 1'b1, 1'b1, 5'd2, 32'hCAFE_BABE);
        end
        flush = 1'b1;
        tick();
        chk_wb("stallflush", 1'b0, 1'b0, 5'd2, 32'hCAFE_BABE);
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'h0000_0777, 32'h0, 5'd6);
        tick();
        chk_wb("resume", 1'b1, 1'b1, 5'd6, 32'h0000_0777);

        // 5: asynchronous reset between edges, during a stall
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk_wb("async_rst", 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk_wb("rst_held", 1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        reset = 1'b1;
        stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'hABCD_EF01, 32'h0, 5'd5);
        tick();
        chk_wb("post_rst", 1'b1, 1'b1, 5'd5, 32'hABCD_EF01);

`ifdef WB_RETIRE_CNT_EN
        // 6: retire counter; 10 instructions, 2 stall cycles, one flushed -> 9 retire
        #2;
        reset = 1'b0;
        #1;
        chk("cnt_rst", retire_cnt, 32'd0);
        #2;
        reset = 1'b1;
        for (int e = 0; e < 13; e++) begin
            stall = (e == 2) || (e == 3);
            flush = (e == 5);
            drive(e != 12, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'(e), 32'h0, 5'd1);
            tick();
        end
        stall = 1'b0;
        flush = 1'b0;
        chk("retire_cnt", retire_cnt, 32'd9);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        chk("retire_idle", retire_cnt, 32'd9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
